// File: rtl/geri_yaz_tamponlu.sv
// ============================================================================
// Module   : geri_yaz_tamponlu
// Brief    : Register-file writeback stage merging the pipeline result with a
//            FIFO of long-latency (divider) results; pipeline has priority and
//            a starvation counter raises a stall request. Optional build macro
//            GERI_YAZ_X0_FILTRE_EN suppresses writes to register x0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module geri_yaz_tamponlu #(
  parameter int               XLEN        = 32,
  parameter int               PS_BIT      = 18,
  parameter logic [XLEN-1:0]  PS_TABAN    = 32'h4000_0000,
  parameter int               DERINLIK    = 4,
  parameter int               ACLIK_SINIR = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        yrt_rd_adres_i,
  input  logic [XLEN-1:0]   yrt_rd_deger_i,
  input  logic [1:0]        yrt_kaynak_i,
  input  logic              yrt_yazmac_i,
  input  logic [PS_BIT-1:0] yrt_ps_artmis_i,
  input  logic [XLEN-1:0]   yrt_carp_deger_i,
  input  logic              uzun_gecerli_i,
  input  logic [4:0]        uzun_rd_adres_i,
  input  logic [XLEN-1:0]   uzun_deger_i,
  output logic              uzun_hazir_o,
  output logic [4:0]        cyo_yaz_adres_o,
  output logic [XLEN-1:0]   cyo_yaz_deger_o,
  output logic              cyo_yaz_yazmac_o,
  output logic              cyo_durdur_o
);

  localparam int c_pw = $clog2(DERINLIK);
  localparam int c_cw = c_pw + 1;
  localparam int c_aw = $clog2(ACLIK_SINIR + 1);
  localparam logic [c_cw-1:0] c_derinlik = c_cw'(DERINLIK);
  localparam logic [c_aw-1:0] c_sinir    = c_aw'(ACLIK_SINIR);

  logic [4:0]      r_fifo_adres [DERINLIK];
  logic [XLEN-1:0] r_fifo_deger [DERINLIK];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_aclik;
  logic            r_durdur;

  logic            w_pipe_gecerli;
  logic [XLEN-1:0] w_deger;
  logic            w_bos;
  logic            w_push;
  logic            w_pop;
  logic            w_pipe_yaz;
  logic            w_tampon_yaz;
  logic [c_aw-1:0] w_aclik_next;

  assign w_pipe_gecerli = yrt_yazmac_i && (yrt_kaynak_i != 2'd3);
  assign w_bos          = (r_count == '0);
  assign uzun_hazir_o   = (r_count < c_derinlik) && !rst_i;
  assign w_push         = uzun_gecerli_i && uzun_hazir_o;
  assign w_pop          = !w_pipe_gecerli && !w_bos;

  always_comb begin
    w_deger = yrt_rd_deger_i;
    case (yrt_kaynak_i)
      2'd1:    w_deger = PS_TABAN | {{(XLEN-PS_BIT-1){1'b0}}, yrt_ps_artmis_i, 1'b0};
      2'd2:    w_deger = yrt_carp_deger_i;
      default: w_deger = yrt_rd_deger_i;
    endcase
  end

`ifdef GERI_YAZ_X0_FILTRE_EN
  // x0 is hardwired zero; drop the write but still let buffered entries retire
  assign w_pipe_yaz   = (yrt_rd_adres_i != 5'd0);
  assign w_tampon_yaz = (r_fifo_adres[r_rd_ptr] != 5'd0);
`else
  assign w_pipe_yaz   = 1'b1;
  assign w_tampon_yaz = 1'b1;
`endif

  always_comb begin
    w_aclik_next = r_aclik;
    if (w_bos || w_pop)
      w_aclik_next = '0;
    else if (r_aclik != c_sinir)
      w_aclik_next = r_aclik + 1'b1;
  end

  // Storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_adres[r_wr_ptr] <= uzun_rd_adres_i;
      r_fifo_deger[r_wr_ptr] <= uzun_deger_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_aclik  <= '0;
      r_durdur <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_aclik  <= w_aclik_next;
      // Stall asserts together with the counter hitting the limit, drops on pop
      r_durdur <= !w_pop && (r_durdur || (w_aclik_next == c_sinir));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyo_yaz_adres_o  <= 5'd0;
      cyo_yaz_deger_o  <= '0;
      cyo_yaz_yazmac_o <= 1'b0;
    end else if (w_pipe_gecerli) begin
      cyo_yaz_adres_o  <= yrt_rd_adres_i;
      cyo_yaz_deger_o  <= w_deger;
      cyo_yaz_yazmac_o <= w_pipe_yaz;
    end else if (w_pop) begin
      cyo_yaz_adres_o  <= r_fifo_adres[r_rd_ptr];
      cyo_yaz_deger_o  <= r_fifo_deger[r_rd_ptr];
      cyo_yaz_yazmac_o <= w_tampon_yaz;
    end else begin
      cyo_yaz_yazmac_o <= 1'b0;
    end
  end

  assign cyo_durdur_o = r_durdur;

endmodule

`default_nettype wire
